simd_product_accumulator: RTL and testbench
===========================================

// Module: simd_product_accumulator
// PURPOSE
// Sits directly downstream of the 27x18 / sum-9x9 / sum-4x4 fracturable multiplier.
// Its result_0/result_1 outputs are a redundant pair whose segments never carry into
// each other; this block resolves them with a lane-partitioned carry-propagate add.
// It then accumulates acc_len consecutive products per lane and emits the total over a
// valid/ready handshake. One clock; reset is asynchronous and active-low.
// PARAMETERS
// ACC_W  48  accumulator width; must be >=45. Bits [ACC_W-1:45] are guard bits, mode 00 only.
// LEN_W  8   width of the acc_len beat-count port.
// PORTS
// clk        in   1      rising-edge clock
// reset_n    in   1      asynchronous active-low reset
// in_valid   in   1      product beat present on result_0/result_1
// in_ready   out  1      beat accepted when in_valid & in_ready at a clk edge
// result_0   in   45     partial-product vector 0 from the multiplier
// result_1   in   45     partial-product vector 1 from the multiplier
// mode       in   2      00 = 27x18, 01 = sum_9x9, 10 = sum_4x4; 11 is handled as 10
// prod_sign  in   1      a_sign|b_sign of the product: sign-extend in mode 00
// acc_len    in   LEN_W  beats per accumulation; 0 is treated as 1
// out_valid  out  1      acc_out holds a finished accumulation
// out_ready  in   1      consumer accepts acc_out
// acc_out    out  ACC_W  accumulated result
// acc_mode   out  2      mode latched for this accumulation
// busy       out  1      state != IDLE or pipeline stage occupied
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE; all registers 0.
//   out_valid=0, acc_out=0, acc_mode=0, busy=0. in_ready is forced 0 while reset_n=0.
// - Lane split points, with carry killed into each split bit:
//   mode 00: no split (one 45-bit lane).
//   mode 01: split at 27; lanes are [26:0] and [44:27].
//   mode 10: split at 17, 27 and 35; lanes are [16:0], [26:17], [34:27] and [44:35].
// - Stage 1 (registered): p = lane-partitioned result_0 + result_1, 45 bits.
// - Guard bits: in mode 00, p is sign-extended to ACC_W when prod_sign=1, else
//   zero-extended. In SIMD modes the guard bits are held at 0.
// - Stage 2: acc <= acc + p, using the same lane partition. Each lane wraps modulo its
//   own width; there is no saturation and no overflow flag.
// - FSM states:
//   IDLE: in_ready=1. The first accepted beat latches mode (to acc_mode), latches
//     max(acc_len,1) as len, sets cnt=1, clears acc, and moves to ACCUM.
//   ACCUM: in_ready=(cnt<len). Each accepted beat increments cnt. The mode and acc_len
//     ports are ignored here. Once cnt==len and the last beat has been added into acc,
//     move to EMIT.
//   EMIT: out_valid=1, in_ready=0, acc_out=acc held stable. On out_ready, move to IDLE,
//     out_valid falls the next cycle, acc_out holds its last value.
// - Latency: the last beat accepted at edge t gives out_valid=1 after edge t+2.
// - Throughput: 1 beat/cycle in ACCUM. in_valid gaps are allowed and do not advance cnt.
// - The first accepted beat with len=1 goes IDLE->ACCUM and reaches EMIT at t+2.
// - A new accumulation cannot start until EMIT is handshaken; there is no overlap.
// - in_valid in EMIT is not accepted and is held off by in_ready=0.
// - reset_n low mid-accumulation: partial sums and in-flight beats are discarded,
//   nothing is emitted, and the block returns to IDLE.
// - A mode change between accumulations takes effect on the next first beat only.
// TESTING
// 1. Mode 00, prod_sign=0, acc_len=1, result_0=45'h10, result_1=45'h5
//    -> out_valid 2 cycles later, acc_out=48'h15, acc_mode=00.
// 2. Mode 00, prod_sign=1, acc_len=3, three beats of result_0=45'h1FFF_FFFF_FFFF, result_1=0
//    -> acc_out=48'hFFFF_FFFF_FFFD.
// 3. Mode 10, result_0[16:0]=17'h1FFFF, result_1[16:0]=17'h1, all other bits 0, acc_len=1
//    -> acc_out=0 (lane 0 wraps, bit 17 stays 0).
// 4. Mode 01, acc_len=2, second beat with in_valid gap of 3 cycles and mode switched to 00
//    -> both lanes summed independently, acc_mode=01, out_valid 2 cycles after beat 2.
// 5. EMIT with out_ready=0 for 5 cycles
//    -> out_valid=1 and acc_out stable, in_ready=0 throughout; IDLE one cycle after ready.
// 6. reset_n pulsed low after beat 2 of acc_len=4
//    -> out_valid never rises; the next run starts with acc=0.
//    acc_len=0 run -> behaves exactly as acc_len=1.

Source files
------------

// File: rtl/simd_product_accumulator.sv
// Resolves the multiplier's redundant result pair with a lane-partitioned add, then
// accumulates acc_len products per SIMD lane and emits the total over valid/ready.
module simd_product_accumulator #(
    parameter int unsigned ACC_W = 48,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [44:0]      result_0,
    input  logic [44:0]      result_1,
    input  logic [1:0]       mode,
    input  logic             prod_sign,
    input  logic [LEN_W-1:0] acc_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [1:0]       acc_mode,
    output logic             busy
);

    localparam int unsigned PW = 45;

    typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

    function automatic logic is_split(input int i, input logic [1:0] m);
        unique case (m)
            2'b00:   return 1'b0;
            2'b01:   return (i == 27);
            default: return (i == 17) || (i == 27) || (i == 35);
        endcase
    endfunction

    // Ripple add with the carry killed into every lane boundary; SIMD modes own no guard bits.
    function automatic logic [ACC_W-1:0] lane_add(input logic [ACC_W-1:0] a,
                                                  input logic [ACC_W-1:0] b,
                                                  input logic [1:0]       m);
        logic [ACC_W-1:0] s;
        logic             c;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < int'(ACC_W); i++) begin
            if (is_split(i, m)) c = 1'b0;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        if (m != 2'b00) begin
            for (int i = int'(PW); i < int'(ACC_W); i++) s[i] = 1'b0;
        end
        return s;
    endfunction

    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? 2'b10 : m;
    endfunction

    state_e           r_state;
    state_e           w_state_d;
    logic [1:0]       r_mode;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_p;
    logic             r_p_vld;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_acc_out;

    logic             w_rdy;
    logic             w_accept;
    logic             w_first;
    logic [1:0]       w_mode_eff;
    logic [LEN_W-1:0] w_len_in;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_p;

    assign in_ready   = reset_n & w_rdy;
    assign w_accept   = in_valid & in_ready;
    assign w_first    = w_accept & (r_state == StIdle);
    assign w_mode_eff = (r_state == StIdle) ? norm_mode(mode) : r_mode;
    assign w_len_in   = (acc_len == '0) ? LEN_W'(1) : acc_len;
    assign w_sum      = lane_add(ACC_W'(result_0), ACC_W'(result_1), w_mode_eff);

    // Guard bits replicate the product's MSB only for signed 27x18 products.
    always_comb begin
        w_p = w_sum;
        for (int i = int'(PW); i < int'(ACC_W); i++) begin
            w_p[i] = (w_mode_eff == 2'b00) & prod_sign & w_sum[PW-1];
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_rdy     = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_rdy = 1'b1;
                if (in_valid) w_state_d = StAccum;
            end
            StAccum: begin
                w_rdy = (r_cnt < r_len);
                // Last beat counted and nothing left in stage 1: acc is final.
                if ((r_cnt == r_len) && !r_p_vld) w_state_d = StEmit;
            end
            StEmit: begin
                if (out_ready) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_mode    <= 2'b00;
            r_len     <= '0;
            r_cnt     <= '0;
            r_p       <= '0;
            r_p_vld   <= 1'b0;
            r_acc     <= '0;
            r_acc_out <= '0;
        end else begin
            r_state <= w_state_d;
            r_p_vld <= w_accept;
            if (w_accept) r_p <= w_p;
            if (w_first) begin
                r_mode <= norm_mode(mode);
                r_len  <= w_len_in;
                r_cnt  <= LEN_W'(1);
                r_acc  <= '0;
            end else begin
                if (w_accept) r_cnt <= r_cnt + LEN_W'(1);
                if (r_p_vld) r_acc <= lane_add(r_acc, r_p, r_mode);
            end
            if ((r_state == StAccum) && (w_state_d == StEmit)) r_acc_out <= r_acc;
        end
    end

    assign out_valid = (r_state == StEmit);
    assign acc_out   = r_acc_out;
    assign acc_mode  = r_mode;
    assign busy      = (r_state != StIdle) | r_p_vld;

endmodule

// File: tb/tb_simd_product_accumulator.sv
// Randomised bench for simd_product_accumulator against a per-lane arithmetic model.
module tb_simd_product_accumulator;

    localparam int unsigned ACC_W = 48;
    localparam int unsigned LEN_W = 8;
    localparam longint unsigned M45  = (64'd1 << 45) - 64'd1;
    localparam longint unsigned MACC = (64'd1 << ACC_W) - 64'd1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [44:0]      result_0 = '0;
    logic [44:0]      result_1 = '0;
    logic [1:0]       mode = 2'b00;
    logic             prod_sign = 1'b0;
    logic [LEN_W-1:0] acc_len = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] acc_out;
    logic [1:0]       acc_mode;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    longint unsigned bt_r0[8];
    longint unsigned bt_r1[8];
    logic [1:0]      bt_mode[8];
    logic            bt_sign[8];
    int              bt_gap[8];

    simd_product_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .result_0(result_0), .result_1(result_1), .mode(mode), .prod_sign(prod_sign),
        .acc_len(acc_len), .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .acc_mode(acc_mode), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned mk(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic longint unsigned lane_sum(input longint unsigned a, input longint unsigned b,
                                                 input int lo, input int w);
        return ((((a >> lo) & mk(w)) + ((b >> lo) & mk(w))) & mk(w)) << lo;
    endfunction

    function automatic longint unsigned simd_add(input longint unsigned a,
                                                 input longint unsigned b, input logic [1:0] m);
        if (m == 2'b01) return lane_sum(a, b, 0, 27) | lane_sum(a, b, 27, 18);
        return lane_sum(a, b, 0, 17) | lane_sum(a, b, 17, 10) | lane_sum(a, b, 27, 8) |
               lane_sum(a, b, 35, 10);
    endfunction

    function automatic longint unsigned model_p(input longint unsigned r0,
                                                input longint unsigned r1,
                                                input logic [1:0] m, input logic sg);
        longint unsigned s;
        if (m != 2'b00) return simd_add(r0, r1, m);
        s = (r0 + r1) & M45;
        if (sg && s[44]) s = s | (MACC & ~M45);
        return s;
    endfunction

    function automatic longint unsigned model_run(input int nb);
        longint unsigned acc = 0;
        logic [1:0] m = bt_mode[0];
        for (int k = 0; k < nb; k++) begin
            if (m == 2'b00) acc = (acc + model_p(bt_r0[k], bt_r1[k], m, bt_sign[k])) & MACC;
            else acc = simd_add(acc, model_p(bt_r0[k], bt_r1[k], m, bt_sign[k]), m);
        end
        return acc;
    endfunction

    function automatic longint unsigned rnd45();
        return {$urandom, $urandom} & M45;
    endfunction

    // Called at a negedge; returns at the negedge after the beat's accepting edge.
    task automatic drive_beat(input int k, input logic [LEN_W-1:0] lenp);
        int n;
        result_0  = bt_r0[k][44:0];
        result_1  = bt_r1[k][44:0];
        mode      = bt_mode[k];
        prod_sign = bt_sign[k];
        acc_len   = (k == 0) ? lenp : LEN_W'($urandom);
        in_valid  = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_accept k=%0d: in_ready=%b, required 1", k, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic do_run(input int nb, input logic [LEN_W-1:0] lenp, input bit hs,
                          output int lat, output longint unsigned got, output logic [1:0] gm);
        for (int k = 0; k < nb; k++) begin
            if (bt_gap[k] > 0) begin
                in_valid = 1'b0;
                repeat (bt_gap[k]) @(negedge clk);
            end
            drive_beat(k, lenp);
        end
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        got = {16'd0, acc_out};
        gm  = acc_mode;
        if (hs) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic set_beat(input int k, input longint unsigned r0, input longint unsigned r1,
                            input logic [1:0] m, input logic sg, input int gap);
        bt_r0[k] = r0; bt_r1[k] = r1; bt_mode[k] = m; bt_sign[k] = sg; bt_gap[k] = gap;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({in_ready, out_valid, busy, acc_mode} !== 5'b0 || acc_out !== '0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b ov=%b busy=%b mode=%b acc=%h, required all 0",
                     in_ready, out_valid, busy, acc_mode, acc_out);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: rdy=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        int lat; longint unsigned got; logic [1:0] gm;
        set_beat(0, 45'h10, 45'h5, 2'b00, 1'b0, 0);
        do_run(1, 8'd1, 1'b1, lat, got, gm);
        n_vec++;
        if (lat !== 2 || got !== 64'h15 || gm !== 2'b00) begin
            n_err++;
            $display("FAIL basic: lat=%0d acc=%h mode=%b, required 2 15 00", lat, got, gm);
        end
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || acc_out !== 48'h15) begin
            n_err++;
            $display("FAIL basic_after_hs: ov=%b busy=%b acc=%h, required 0 0 15",
                     out_valid, busy, acc_out);
        end
    endtask

    task automatic test_sign_ext();
        int lat; longint unsigned got; logic [1:0] gm;
        for (int k = 0; k < 3; k++) set_beat(k, 45'h1FFF_FFFF_FFFF, 0, 2'b00, 1'b1, 0);
        do_run(3, 8'd3, 1'b1, lat, got, gm);
        n_vec++;
        if (lat !== 2 || got !== 64'hFFFF_FFFF_FFFD) begin
            n_err++;
            $display("FAIL sign_ext: lat=%0d acc=%h, required 2 fffffffffffd", lat, got);
        end
    endtask

    task automatic test_lane_wrap();
        int lat; longint unsigned got; logic [1:0] gm;
        set_beat(0, 45'h1FFFF, 45'h1, 2'b10, 1'b0, 0);
        do_run(1, 8'd1, 1'b1, lat, got, gm);
        n_vec++;
        if (lat !== 2 || got !== 64'h0 || gm !== 2'b10) begin
            n_err++;
            $display("FAIL lane_wrap: lat=%0d acc=%h mode=%b, required 2 0 10", lat, got, gm);
        end
    endtask

    task automatic test_gap_mode_switch();
        int lat; longint unsigned got, exp; logic [1:0] gm;
        set_beat(0, rnd45(), rnd45(), 2'b01, 1'b0, 0);
        set_beat(1, 45'h7FF_FFFF, 45'h1, 2'b00, 1'b1, 3);
        exp = model_run(2);
        do_run(2, 8'd2, 1'b1, lat, got, gm);
        n_vec++;
        if (lat !== 2 || got !== exp || gm !== 2'b01) begin
            n_err++;
            $display("FAIL gap_mode_switch: lat=%0d acc=%h mode=%b, required 2 %h 01",
                     lat, got, gm, exp);
        end
    endtask

    task automatic test_backpressure();
        int lat; longint unsigned got, exp; logic [1:0] gm;
        set_beat(0, rnd45(), rnd45(), 2'b00, 1'b1, 0);
        set_beat(1, rnd45(), rnd45(), 2'b00, 1'b0, 0);
        exp = model_run(2);
        do_run(2, 8'd2, 1'b0, lat, got, gm);
        n_vec++;
        if (lat !== 2 || got !== exp) begin
            n_err++;
            $display("FAIL bp_result: lat=%0d acc=%h, required 2 %h", lat, got, exp);
        end
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {16'd0, acc_out} !== exp) begin
                n_err++;
                $display("FAIL bp_hold c=%0d: ov=%b rdy=%b acc=%h, required 1 0 %h",
                         c, out_valid, in_ready, acc_out, exp);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            {16'd0, acc_out} !== exp) begin
            n_err++;
            $display("FAIL bp_release: ov=%b rdy=%b busy=%b acc=%h, required 0 1 0 %h",
                     out_valid, in_ready, busy, acc_out, exp);
        end
    endtask

    task automatic test_reset_mid();
        int lat; longint unsigned got, exp; logic [1:0] gm; bit seen;
        for (int k = 0; k < 2; k++) set_beat(k, rnd45(), rnd45(), 2'b01, 1'b0, 0);
        acc_len = 8'd4;
        drive_beat(0, 8'd4);
        drive_beat(1, 8'd4);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_low: rdy=%b busy=%b ov=%b, required 0 0 0",
                     in_ready, busy, out_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_mid_emit: out_valid rose=%b, required 0", seen);
        end
        set_beat(0, rnd45(), rnd45(), 2'b10, 1'b0, 0);
        exp = model_run(1);
        do_run(1, 8'd1, 1'b1, lat, got, gm);
        n_vec++;
        if (lat !== 2 || got !== exp || gm !== 2'b10) begin
            n_err++;
            $display("FAIL reset_mid_next: lat=%0d acc=%h mode=%b, required 2 %h 10",
                     lat, got, gm, exp);
        end
    endtask

    task automatic test_len_zero();
        int lat; longint unsigned got, exp; logic [1:0] gm;
        set_beat(0, rnd45(), rnd45(), 2'b01, 1'b0, 0);
        exp = model_run(1);
        do_run(1, 8'd0, 1'b1, lat, got, gm);
        n_vec++;
        if (lat !== 2 || got !== exp || gm !== 2'b01) begin
            n_err++;
            $display("FAIL len_zero: lat=%0d acc=%h mode=%b, required 2 %h 01",
                     lat, got, gm, exp);
        end
    endtask

    task automatic test_random();
        int lat, nb, lenp; longint unsigned got, exp; logic [1:0] m, gm;
        for (int r = 0; r < 16; r++) begin
            m    = 2'($urandom_range(0, 2));
            lenp = $urandom_range(0, 7);
            nb   = (lenp == 0) ? 1 : lenp;
            for (int k = 0; k < nb; k++) begin
                set_beat(k, rnd45(), rnd45(), (k == 0) ? m : 2'($urandom_range(0, 3)),
                         1'($urandom), $urandom_range(0, 2));
            end
            exp = model_run(nb);
            do_run(nb, LEN_W'(lenp), 1'b1, lat, got, gm);
            n_vec++;
            if (lat !== 2 || got !== exp || gm !== m) begin
                n_err++;
                $display("FAIL random r=%0d: lat=%0d acc=%h mode=%b, required 2 %h %b",
                         r, lat, got, gm, exp, m);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat; longint unsigned got, exp; logic [1:0] gm;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) set_beat(k, rnd45(), rnd45(), 2'(r), 1'b1, 0);
            exp = model_run(4);
            do_run(4, 8'd4, 1'b1, lat, got, gm);
            n_vec++;
            if (lat !== 2 || got !== exp || gm !== 2'(r)) begin
                n_err++;
                $display("FAIL back_to_back r=%0d: lat=%0d acc=%h mode=%b, required 2 %h %0d",
                         r, lat, got, gm, exp, r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_ext();
        test_lane_wrap();
        test_gap_mode_switch();
        test_backpressure();
        test_reset_mid();
        test_len_zero();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
